// File: rtl/axi_lite_cmd_master.sv
// -----------------------------------------------------------------------------
// axi_lite_cmd_master
//
// Single-outstanding AXI4-Lite master. It accepts read/write commands on a local
// valid/ready port, runs exactly one AXI4-Lite transaction per command, and
// returns the read data and RRESP/BRESP on a valid/ready response port.
// All AXI and response outputs are registered, so there is no combinational
// path from any input to any output.
//
// Optional feature: define AXIL_MASTER_TIMEOUT_EN to build the response
// watchdog. When it is undefined, no counter exists and timeout_err is tied to 0.
//
// Parameters:
//   ADDR_W   address width in bits
//   DATA_W   data width in bits (32 or 64)
//   TIMEOUT  watchdog limit in cycles (>= 1)
//
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb
//                                 local command port
//   rsp_valid/ready/write/data/resp
//                                 local response port
//   timeout_err                   sticky watchdog flag
//   m_axi_aw*, m_axi_w*, m_axi_b* AXI4-Lite write channels
//   m_axi_ar*, m_axi_r*           AXI4-Lite read channels
//
// State     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | cmd_ready high, waiting for a command
// RADDR     | arvalid high, waiting for arready
// RDATA     | rready high, waiting for rvalid
// WRITE     | awvalid/wvalid issued together, waiting for both handshakes
// WRESP     | bready high, waiting for bvalid
// RSP       | rsp_valid high, fields held until rsp_ready
// -----------------------------------------------------------------------------
module axi_lite_cmd_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [1:0]            rsp_resp,

    output logic                  timeout_err,

    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RADDR = 3'd1;
    localparam logic [2:0] ST_RDATA = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_WRESP = 3'd4;
    localparam logic [2:0] ST_RSP   = 3'd5;

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
            $error("axi_lite_cmd_master: DATA_W must be 32 or 64");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("axi_lite_cmd_master: TIMEOUT must be at least 1");
        end
    endgenerate

    logic [2:0] state;
    logic       aw_done;
    logic       w_done;
    logic       cmd_hs;
    logic       aw_hs;
    logic       w_hs;

    // cmd_ready is only ever high in IDLE, so it alone qualifies the handshake.
    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_hs   = m_axi_wvalid && m_axi_wready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_data      <= '0;
            rsp_resp      <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Comes up one cycle after reset release.
                    cmd_ready <= 1'b1;
                    if (cmd_hs) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= ST_WRITE;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RADDR;
                        end
                    end
                end

                ST_RADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RDATA;
                    end
                end

                ST_RDATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_data     <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_write    <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end

                ST_WRITE: begin
                    // AW and W complete independently; each valid drops right
                    // after its own handshake, the other keeps waiting.
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WRESP;
                    end
                end

                ST_WRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_data     <= '0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_write    <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             busy;

    assign busy = (state == ST_RADDR) || (state == ST_RDATA) ||
                  (state == ST_WRITE) || (state == ST_WRESP);

    // Counter saturates at TIMEOUT; the flag is only reporting, the
    // transaction itself keeps waiting on the slave.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (cmd_hs) begin
            wd_cnt <= '0;
        end else if (busy) begin
            if (wd_cnt != CNT_W'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
module tb_axi_lite_cmd_master;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic              aclk;
    logic              areset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_resp;
    logic              timeout_err;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    int errors = 0;
    int checks = 0;

    axi_lite_cmd_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(8)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_write    (rsp_write),
        .rsp_data     (rsp_data),
        .rsp_resp     (rsp_resp),
        .timeout_err  (timeout_err),
        .m_axi_awaddr (awaddr),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .m_axi_araddr (araddr),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance one cycle; inputs driven and outputs sampled 1 ns after the edge.
    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout_err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout_err});
        end
        checks++;
        if ({awaddr, araddr, wdata, wstrb, rsp_data, rsp_resp} !== '0) begin
            errors++;
            $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h wstrb=%h rsp_data=%h rsp_resp=%b expected all 0",
                     awaddr, araddr, wdata, wstrb, rsp_data, rsp_resp);
        end
        areset = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    // Read with two AR wait states.
    task automatic test_read;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h004; arready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            cmd_valid = 1'b0;
            checks++;
            if ({arvalid, araddr, rready, cmd_ready} !== {1'b1, 12'h004, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL read_ar_hold c%0d: arvalid=%b araddr=%h rready=%b cmd_ready=%b expected 1 004 0 0",
                         c, arvalid, araddr, rready, cmd_ready);
            end
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++;
        if ({arvalid, rready} !== 2'b01) begin
            errors++;
            $display("FAIL read_rready: arvalid,rready=%b expected 01", {arvalid, rready});
        end
        rvalid = 1'b1; rdata = 32'hA5A5_0001; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_write, rsp_resp, rsp_data, rready} !== {1'b1, 1'b0, 2'b00, 32'hA5A5_0001, 1'b0}) begin
            errors++;
            $display("FAIL read_rsp: valid=%b write=%b resp=%b data=%h rready=%b expected 1 0 00 a5a50001 0",
                     rsp_valid, rsp_write, rsp_resp, rsp_data, rready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL read_done: rsp_valid,cmd_ready=%b expected 01", {rsp_valid, cmd_ready});
        end
    endtask

    // awready in cycle 1, wready in cycle 4, bready expected in cycle 5.
    task automatic test_write_skew;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h010;
        cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hC;
        awready = 1'b1; wready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({awvalid, wvalid, awaddr, wdata, wstrb, bready} !== {1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 4'hC, 1'b0}) begin
            errors++;
            $display("FAIL wr_issue: awvalid=%b wvalid=%b awaddr=%h wdata=%h wstrb=%h bready=%b expected 1 1 010 deadbeef c 0",
                     awvalid, wvalid, awaddr, wdata, wstrb, bready);
        end
        for (int c = 2; c <= 4; c++) begin
            tick();
            awready = 1'b0;
            checks++;
            if ({awvalid, wvalid, wdata, wstrb, bready} !== {1'b0, 1'b1, 32'hDEAD_BEEF, 4'hC, 1'b0}) begin
                errors++;
                $display("FAIL wr_w_hold c%0d: awvalid=%b wvalid=%b wdata=%h wstrb=%h bready=%b expected 0 1 deadbeef c 0",
                         c, awvalid, wvalid, wdata, wstrb, bready);
            end
        end
        wready = 1'b1;
        tick();
        wready = 1'b0;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            errors++;
            $display("FAIL wr_bready_c5: awvalid,wvalid,bready=%b expected 001", {awvalid, wvalid, bready});
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_write, rsp_resp, rsp_data, bready} !== {1'b1, 1'b1, 2'b00, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL wr_rsp: valid=%b write=%b resp=%b data=%h bready=%b expected 1 1 00 00000000 0",
                     rsp_valid, rsp_write, rsp_resp, rsp_data, bready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Minimum-latency write returning SLVERR, with the next command pending.
    task automatic test_error_resp;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020;
        cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
        awready = 1'b1; wready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b110) begin
            errors++;
            $display("FAIL err_c1: awvalid,wvalid,bready=%b expected 110", {awvalid, wvalid, bready});
        end
        tick();
        awready = 1'b0; wready = 1'b0;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            errors++;
            $display("FAIL err_c2: awvalid,wvalid,bready=%b expected 001", {awvalid, wvalid, bready});
        end
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1110) begin
            errors++;
            $display("FAIL err_c3_rsp: valid,write,resp=%b expected 1110", {rsp_valid, rsp_write, rsp_resp});
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h008; arready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({cmd_ready, arvalid, rsp_valid} !== 3'b001) begin
                errors++;
                $display("FAIL err_block_cmd %0d: cmd_ready,arvalid,rsp_valid=%b expected 001",
                         c, {cmd_ready, arvalid, rsp_valid});
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, arvalid} !== 3'b010) begin
            errors++;
            $display("FAIL err_release: rsp_valid,cmd_ready,arvalid=%b expected 010", {rsp_valid, cmd_ready, arvalid});
        end
    endtask

    // Continues: the pending read is accepted now, with minimum latency.
    task automatic test_back_to_back;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({arvalid, araddr, cmd_ready} !== {1'b1, 12'h008, 1'b0}) begin
            errors++;
            $display("FAIL b2b_c1: arvalid=%b araddr=%h cmd_ready=%b expected 1 008 0", arvalid, araddr, cmd_ready);
        end
        tick();
        arready = 1'b0;
        checks++;
        if ({arvalid, rready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_c2: arvalid,rready=%b expected 01", {arvalid, rready});
        end
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b11;
        tick();
        rvalid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_write, rsp_resp, rsp_data} !== {1'b1, 1'b0, 2'b11, 32'h1234_5678}) begin
            errors++;
            $display("FAIL b2b_c3_rsp: valid=%b write=%b resp=%b data=%h expected 1 0 11 12345678",
                     rsp_valid, rsp_write, rsp_resp, rsp_data);
        end
    endtask

    // Continues from a held read response: 5 cycles of rsp_ready low.
    task automatic test_backpressure;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h040;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({rsp_valid, rsp_write, rsp_resp, rsp_data} !== {1'b1, 1'b0, 2'b11, 32'h1234_5678}) begin
                errors++;
                $display("FAIL bp_hold %0d: valid=%b write=%b resp=%b data=%h expected 1 0 11 12345678",
                         c, rsp_valid, rsp_write, rsp_resp, rsp_data);
            end
            checks++;
            if ({cmd_ready, arvalid, awvalid, wvalid, rready, bready} !== 6'b0) begin
                errors++;
                $display("FAIL bp_quiet %0d: cmd_ready,arvalid,awvalid,wvalid,rready,bready=%b expected 000000",
                         c, {cmd_ready, arvalid, awvalid, wvalid, rready, bready});
            end
        end
        cmd_valid = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: rsp_valid,cmd_ready=%b expected 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_reset_mid;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h00C; arready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_rdata: rready=%b expected 1", rready);
        end
        areset = 1'b1;
        tick();
        checks++;
        if ({rready, rsp_valid, arvalid, cmd_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_abort: rready,rsp_valid,arvalid,cmd_ready=%b expected 0000",
                     {rready, rsp_valid, arvalid, cmd_ready});
        end
        areset = 1'b0;
        tick();
        checks++;
        if ({cmd_ready, rready, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_release: cmd_ready,rready,rsp_valid=%b expected 100", {cmd_ready, rready, rsp_valid});
        end
    endtask

    // arready withheld 20 cycles; with TIMEOUT=8 the flag shows from cycle 9.
    task automatic test_watchdog;
        logic exp_to;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h030; arready = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            cmd_valid = 1'b0;
            exp_to = WD_ON && (c >= 9);
            checks++;
            if ({arvalid, timeout_err} !== {1'b1, exp_to}) begin
                errors++;
                $display("FAIL wd_wait c%0d: arvalid=%b timeout_err=%b expected 1 %b", c, arvalid, timeout_err, exp_to);
            end
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFE_0030; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_data, rsp_resp, timeout_err} !== {1'b1, 32'hCAFE_0030, 2'b00, WD_ON}) begin
            errors++;
            $display("FAIL wd_complete: valid=%b data=%h resp=%b timeout_err=%b expected 1 cafe0030 00 %b",
                     rsp_valid, rsp_data, rsp_resp, timeout_err, WD_ON);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({cmd_ready, timeout_err} !== {1'b1, WD_ON}) begin
            errors++;
            $display("FAIL wd_sticky: cmd_ready=%b timeout_err=%b expected 1 %b", cmd_ready, timeout_err, WD_ON);
        end
    endtask

    initial begin
        areset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0;
        bresp = 2'b00; bvalid = 1'b0;
        arready = 1'b0;
        rdata = '0; rresp = 2'b00; rvalid = 1'b0;

        test_reset();
        test_read();
        test_write_skew();
        test_error_resp();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_watchdog();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
